// File: rtl/det4_host.sv
// det4_host: sequential front end for the combinational 4x4 determinant unit.
//
// Collects sixteen signed 8-bit elements (row-major) over a valid/ready
// stream, packs them onto the 128-bit matrix bus, lets the determinant unit
// settle for SETTLE_CYC cycles, then captures its determinant/overflow and
// offers them on a valid/ready result port.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   clear           synchronous abort of any partial/pending operation
//   in_valid/ready  element stream handshake, in_data = signed element
//   mat             packed matrix, a(i,j) at [127-8*(4i+j) -: 8]
//   det_in, ovf_in  determinant unit outputs
//   res_valid/ready result handshake, res_det/res_ovf = captured result
//   elem_cnt        elements accepted in the current operation (0..16)
//   busy            high while settling or holding a result
module det4_host #(
    parameter int SETTLE_CYC = 2    // legal range 1..15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic [127:0] mat,
    input  logic [7:0]   det_in,
    input  logic         ovf_in,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [7:0]   res_det,
    output logic         res_ovf,
    output logic [4:0]   elem_cnt,
    output logic         busy
);

    typedef enum logic [1:0] {LOAD, SETTLE, RESP} state_t;

    state_t     state, state_nxt;
    logic [3:0] settle_cnt;
    logic       accept;
    logic       last_elem;
    logic       capture;
    logic       res_take;

    assign last_elem = (elem_cnt == 5'd15);

    always_ff @(posedge clk) begin
        if (!rst) state <= LOAD;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        res_take  = 1'b0;
        case (state)
            LOAD: begin
                in_ready = rst;
                accept   = in_valid & rst;
                if (accept && last_elem) state_nxt = SETTLE;
            end
            SETTLE: begin
                busy = rst;
                if (settle_cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                busy = rst;
                if (res_valid && res_ready) begin
                    res_take  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
        if (clear) state_nxt = LOAD;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mat        <= '0;
            elem_cnt   <= '0;
            settle_cnt <= '0;
            res_valid  <= 1'b0;
            res_det    <= '0;
            res_ovf    <= 1'b0;
        end else if (clear) begin
            mat        <= '0;
            elem_cnt   <= '0;
            settle_cnt <= '0;
            res_valid  <= 1'b0;
        end else begin
            if (accept) begin
                // Slot k sits at the top of the bus for k=0 (row-major, MSB first).
                for (int k = 0; k < 16; k++)
                    if (elem_cnt[3:0] == 4'(k)) mat[127-8*k -: 8] <= in_data;
                elem_cnt <= elem_cnt + 5'd1;
                if (last_elem) settle_cnt <= 4'(SETTLE_CYC - 1);
            end
            if (state == SETTLE) begin
                if (capture) begin
                    res_det   <= det_in;
                    res_ovf   <= ovf_in;
                    res_valid <= 1'b1;
                end else begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
            end
            // mat is left as-is; the next load overwrites it slot by slot.
            if (res_take) begin
                res_valid <= 1'b0;
                elem_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_det4_host.sv
module tb_det4_host;

    localparam int SETTLE = 2;

    typedef struct packed {
        logic [7:0] det;
        logic       ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, clear, in_valid, in_ready;
    logic [7:0]   in_data, det_in, res_det;
    logic [127:0] mat;
    logic         ovf_in, res_valid, res_ready, res_ovf, busy;
    logic [4:0]   elem_cnt;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sbq[$];

    det4_host #(.SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mat(mat), .det_in(det_in), .ovf_in(ovf_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_det(res_det), .res_ovf(res_ovf),
        .elem_cnt(elem_cnt), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Full-precision 4x4 determinant, element k = a(k/4, k%4).
    function automatic longint det4f(input logic [15:0][7:0] m);
        longint a[16];
        longint r, d3;
        int cc[3];
        int n;
        for (int k = 0; k < 16; k++) a[k] = longint'($signed(m[k]));
        r = 0;
        for (int c = 0; c < 4; c++) begin
            n = 0;
            for (int j = 0; j < 4; j++) if (j != c) begin cc[n] = j; n++; end
            d3 = a[4+cc[0]] * (a[8+cc[1]]*a[12+cc[2]] - a[8+cc[2]]*a[12+cc[1]])
               - a[4+cc[1]] * (a[8+cc[0]]*a[12+cc[2]] - a[8+cc[2]]*a[12+cc[0]])
               + a[4+cc[2]] * (a[8+cc[0]]*a[12+cc[1]] - a[8+cc[1]]*a[12+cc[0]]);
            r += ((c % 2) == 0 ? a[c] : -a[c]) * d3;
        end
        return r;
    endfunction

    function automatic logic [127:0] pack(input logic [15:0][7:0] m);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = m[k];
        return r;
    endfunction

    function automatic logic [15:0][7:0] diag(input logic [7:0] v);
        logic [15:0][7:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) m[5*k] = v;
        return m;
    endfunction

    // Stand-in for the determinant unit, driven from the packed bus.
    always_comb begin
        logic [15:0][7:0] um;
        longint d;
        for (int k = 0; k < 16; k++) um[k] = mat[127-8*k -: 8];
        d      = det4f(um);
        det_in = d[7:0];
        ovf_in = (d > 127) || (d < -128);
    end

    // Scoreboard: a handshake happens at the next edge when both are high here.
    always @(negedge clk) begin
        if (rst && !clear && res_valid && res_ready) begin
            if (sbq.size() == 0) chk("sb_unexpected", 1, 0);
            else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_det", res_det, e.det);
                chk("sb_ovf", res_ovf, e.ovf);
            end
        end
    end

    task automatic send(input logic [15:0][7:0] m, input int n, input bit gaps, input bit push);
        int guard;
        if (push) begin
            exp_t e;
            longint d;
            d     = det4f(m);
            e.det = d[7:0];
            e.ovf = (d > 127) || (d < -128);
            sbq.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            if (gaps) while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = m[k];
            guard    = 0;
            while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
            if (guard >= 200) chk("accept_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_res(output int at);
        int guard;
        guard = 0;
        at    = -1;
        while (guard < 100) begin
            @(posedge clk); #1;
            if (res_valid) begin at = cyc; break; end
            guard++;
        end
        if (at < 0) chk("res_timeout", 0, 1);
    endtask

    initial begin
        logic [15:0][7:0] m;
        logic [7:0]       held_det;
        logic             held_ovf;
        int               e16, rise;

        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mat", mat, 0);
        chk("rst_cnt", elem_cnt, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_det", res_det, 0);
        chk("rst_ovf", res_ovf, 0);
        rst = 1'b1;
        #1;
        chk("rst_release_ready", in_ready, 1);

        // Identity, back-to-back, res_ready tied high: latency and return to LOAD
        res_ready = 1'b1;
        m = diag(8'd1);
        send(m, 16, 0, 1);
        e16 = cyc;
        chk("id_cnt16", elem_cnt, 16);
        chk("id_busy", busy, 1);
        chk("id_ready_lo", in_ready, 0);
        chk("id_mat", mat, pack(m));
        wait_res(rise);
        chk("id_latency", rise - e16, SETTLE);
        chk("id_det", res_det, 8'd1);
        chk("id_ovf", res_ovf, 0);
        @(posedge clk); #1;
        chk("id_valid_drop", res_valid, 0);
        chk("id_ready_back", in_ready, 1);
        chk("id_cnt_zero", elem_cnt, 0);

        // diag(2) then all-3s: second load fully overwrites the first
        send(diag(8'd2), 16, 0, 1);
        wait_res(rise);
        chk("d2_det", res_det, 8'd16);
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) m[k] = 8'd3;
        send(m, 16, 0, 1);
        chk("all3_mat", mat, pack(m));
        wait_res(rise);
        chk("all3_det", res_det, 8'd0);
        chk("all3_ovf", res_ovf, 0);
        @(posedge clk); #1;

        // diag(4): overflow, result held under back-pressure
        res_ready = 1'b0;
        send(diag(8'd4), 16, 0, 1);
        wait_res(rise);
        chk("d4_ovf", res_ovf, 1);
        chk("d4_det", res_det, 8'd0);
        held_det = res_det;
        held_ovf = res_ovf;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", res_valid, 1);
            chk("hold_det", res_det, held_det);
            chk("hold_ovf", res_ovf, held_ovf);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("d4_release", res_valid, 0);

        // Random matrix with gaps; junk offered during SETTLE/RESP is ignored
        res_ready = 1'b0;
        for (int k = 0; k < 16; k++) m[k] = 8'($urandom_range(0, 6) - 3);
        send(m, 16, 1, 1);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("rnd_cnt_hold", elem_cnt, 16);
            chk("rnd_mat_slots", mat, pack(m));
        end
        chk("rnd_valid", res_valid, 1);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("rnd_release", res_valid, 0);

        // clear after element 7, then a fresh identity
        send(diag(8'd9), 7, 0, 0);
        chk("clr_cnt7", elem_cnt, 7);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_mat", mat, 0);
        chk("clr_cnt", elem_cnt, 0);
        send(diag(8'd1), 16, 0, 1);
        wait_res(rise);
        chk("clr_id_det", res_det, 8'd1);
        @(posedge clk); #1;

        // rst during SETTLE: everything back to reset values, no result
        send(diag(8'd2), 16, 0, 0);
        chk("rs_busy", busy, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rs_mat", mat, 0);
        chk("rs_cnt", elem_cnt, 0);
        chk("rs_det", res_det, 0);
        chk("rs_ovf", res_ovf, 0);
        chk("rs_ready", in_ready, 0);
        chk("rs_busy_lo", busy, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rs_no_valid", res_valid, 0);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rs_no_valid_after", res_valid, 0);
        end
        send(diag(8'hFF), 16, 0, 1);
        wait_res(rise);
        chk("rs_neg_det", res_det, 8'd1);
        @(posedge clk); #1;

        chk("sb_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
